// File: rtl/pipe_delay_line_pkg.sv
// rtl/pipe_delay_line_pkg.sv - width helpers shared by the delay line, its stages and its interface
package pipe_delay_line_pkg;

   // Ceiling log2 for elaboration-time widths; clog2(1) is 0
   function automatic int clog2(input int value);
      int result;
      int rest;
      result = 0;
      rest   = value - 1;
      while (rest > 0) begin
         result++;
         rest = rest >> 1;
      end
      return result;
   endfunction

   // A vector is never narrower than one bit, even when one value would fit in zero
   function automatic int width_min1(input int value);
      return (value < 1) ? 1 : value;
   endfunction

   // Width of the output stage select
   function automatic int tap_width(input int depth);
      return width_min1(clog2(depth));
   endfunction

   // Width of the occupancy counter, which must be able to hold DEPTH itself
   function automatic int cnt_width(input int depth);
      return width_min1(clog2(depth + 1));
   endfunction

endpackage

// File: rtl/pipe_delay_line_if.sv
// rtl/pipe_delay_line_if.sv - control, data and status bundle of the delay line
interface pipe_delay_line_if
   import pipe_delay_line_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int TAP_W = tap_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic             en;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic [TAP_W-1:0] tap_sel;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] stage_count;
   logic             full;

   modport master (
      output en, flush, in_valid, in_data, tap_sel,
      input  out_valid, out_data, stage_count, full
   );

   modport slave (
      input  en, flush, in_valid, in_data, tap_sel,
      output out_valid, out_data, stage_count, full
   );

endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one data/valid register stage with stall, flush and async reset
module pipe_stage
   import pipe_delay_line_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic             prev_valid,
   input  logic [WIDTH-1:0] prev_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Flush beats advance; without either the stage holds its word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (en) begin
         valid <= prev_valid;
         data  <= prev_data;
      end
   end

endmodule

// File: rtl/pipe_delay_line.sv
// rtl/pipe_delay_line.sv - stallable register delay line with selectable output tap and occupancy count
module pipe_delay_line
   import pipe_delay_line_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic              clk,
   input logic              rst_n,
   pipe_delay_line_if.slave bus
);
   localparam int TAP_W = tap_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [CNT_W-1:0] count;

   genvar k;
   generate
      for (k = 0; k < DEPTH; k++) begin : g_stage
         if (k == 0) begin : g_head
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
               .clk        (clk),
               .rst_n      (rst_n),
               .en         (bus.en),
               .flush      (bus.flush),
               .prev_valid (bus.in_valid),
               .prev_data  (bus.in_data),
               .valid      (valid[k]),
               .data       (data[k])
            );
         end else begin : g_body
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
               .clk        (clk),
               .rst_n      (rst_n),
               .en         (bus.en),
               .flush      (bus.flush),
               .prev_valid (valid[k-1]),
               .prev_data  (data[k-1]),
               .valid      (valid[k]),
               .data       (data[k])
            );
         end
      end

      if (DEPTH == 1) begin : g_single_tap
         // With one stage there is nothing to select, so tap_sel is ignored
         logic unused_tap;
         assign unused_tap    = ^bus.tap_sel;
         assign bus.out_valid = valid[0];
         assign bus.out_data  = data[0];
      end else begin : g_tap_mux
         localparam logic [TAP_W:0]   DEPTH_X  = (TAP_W + 1)'(DEPTH);
         localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(DEPTH - 1);
         logic [TAP_W-1:0] tap;

         // Clamp out-of-range selects onto the last stage so the mux never reads past the chain
         always_comb begin
            tap = bus.tap_sel;
            if ({1'b0, bus.tap_sel} >= DEPTH_X) begin
               tap = LAST_TAP;
            end
         end

         assign bus.out_valid = valid[tap];
         assign bus.out_data  = data[tap];
      end
   endgenerate

   // Occupancy: a valid word entering adds one, a valid word falling off the end removes one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (bus.flush) begin
         count <= '0;
      end else if (bus.en) begin
         if (bus.in_valid && !valid[DEPTH-1]) begin
            count <= count + CNT_W'(1);
         end else if (!bus.in_valid && valid[DEPTH-1]) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   assign bus.stage_count = count;
   assign bus.full        = (count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_pipe_delay_line.sv
// tb/tb_pipe_delay_line.sv - self-checking bench for pipe_delay_line at depths 4 and 3
module tb_pipe_delay_line;
   import pipe_delay_line_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       en       = 1'b0;
   logic       flush    = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic [1:0] tap      = 2'd0;

   int checks = 0;
   int errors = 0;

   pipe_delay_line_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
   pipe_delay_line_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

   assign bus4.en = en;  assign bus4.flush = flush;  assign bus4.in_valid = in_valid;
   assign bus4.in_data = in_data;  assign bus4.tap_sel = tap;
   assign bus3.en = en;  assign bus3.flush = flush;  assign bus3.in_valid = in_valid;
   assign bus3.in_data = in_data;  assign bus3.tap_sel = tap;

   pipe_delay_line #(.WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   pipe_delay_line #(.WIDTH(8), .DEPTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

   // Reference: the history of words accepted on enabled edges, newest first, trimmed to depth
   logic [8:0] hist4 [$];
   logic [8:0] hist3 [$];

   function automatic logic [8:0] word_at(input logic [8:0] h [$], input int idx);
      return (idx < h.size()) ? h[idx] : 9'h000;
   endfunction

   function automatic int valid_words(input logic [8:0] h [$]);
      int n = 0;
      foreach (h[i]) n += int'(h[i][8]);
      return n;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (flush) begin
         hist4.delete();
         hist3.delete();
      end else if (en) begin
         hist4.push_front({in_valid, in_data});
         hist3.push_front({in_valid, in_data});
         if (hist4.size() > 4) void'(hist4.pop_back());
         if (hist3.size() > 3) void'(hist3.pop_back());
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      int t3;
      logic [8:0] e4, e3;
      t3 = (int'(tap) > 2) ? 2 : int'(tap);
      e4 = word_at(hist4, int'(tap));
      e3 = word_at(hist3, t3);
      check({tag, ".v4"},   32'(bus4.out_valid),   32'(e4[8]));
      check({tag, ".d4"},   32'(bus4.out_data),    32'(e4[7:0]));
      check({tag, ".cnt4"}, 32'(bus4.stage_count), 32'(valid_words(hist4)));
      check({tag, ".full4"}, 32'(bus4.full),       32'(valid_words(hist4) == 4));
      check({tag, ".v3"},   32'(bus3.out_valid),   32'(e3[8]));
      check({tag, ".d3"},   32'(bus3.out_data),    32'(e3[7:0]));
      check({tag, ".cnt3"}, 32'(bus3.stage_count), 32'(valid_words(hist3)));
      check({tag, ".full3"}, 32'(bus3.full),       32'(valid_words(hist3) == 3));
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   initial begin
      logic       pat [7]     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      int         exp_cnt [7] = '{1, 1, 2, 3, 2, 3, 3};
      logic [7:0] w0;

      // Reset state while rst_n is held low
      #2;
      check_model("reset");
      #10;
      rst_n = 1'b1;

      // Latency per tap: a single 0xA5 shows at tap t exactly once, t edges after its input edge
      en = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tap = 2'(t);
         do_flush();
         in_valid = 1'b1;
         in_data  = 8'hA5;
         step();
         in_valid = 1'b0;
         for (int k = 0; k < 6; k++) begin
            check($sformatf("lat.t%0d.k%0d.valid", t, k), 32'(bus4.out_valid), 32'(k == t));
            if (k == t) check($sformatf("lat.t%0d.data", t), 32'(bus4.out_data), 32'hA5);
            check_model("lat");
            in_data = 8'($urandom);
            step();
         end
      end

      // Stall: fill with 1..4 at tap 3, then hold en low for three edges
      tap = 2'd3;
      do_flush();
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         step();
      end
      en      = 1'b0;
      in_data = 8'h99;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall.data", 32'(bus4.out_data), 32'h01);
         check("stall.valid", 32'(bus4.out_valid), 32'h1);
         check("stall.count", 32'(bus4.stage_count), 32'd4);
         check("stall.full", 32'(bus4.full), 32'h1);
      end
      en = 1'b1;
      for (int i = 5; i <= 8; i++) begin
         in_data = 8'(i);
         step();
         check("resume.data", 32'(bus4.out_data), 32'(i - 3));
         check_model("resume");
      end

      // Flush wins over en and drops the word offered on the same edge
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h77;
      step();
      flush = 1'b0;
      en    = 1'b0;
      for (int t = 0; t < 4; t++) begin
         tap = 2'(t);
         #1;
         check($sformatf("flush.valid.t%0d", t), 32'(bus4.out_valid), 32'h0);
      end
      check("flush.count", 32'(bus4.stage_count), 32'd0);
      en       = 1'b1;
      in_valid = 1'b0;
      tap      = 2'd1;
      step();
      check("flush.dropped.valid", 32'(bus4.out_valid), 32'h0);
      check("flush.dropped.data", 32'(bus4.out_data), 32'h00);

      // Bubbles: occupancy equals the valid words among the last four enabled edges
      do_flush();
      tap = 2'd3;
      for (int i = 0; i < 7; i++) begin
         in_valid = pat[i];
         in_data  = 8'($urandom);
         step();
         check($sformatf("bubble.count.%0d", i), 32'(bus4.stage_count), 32'(exp_cnt[i]));
         check_model("bubble");
      end

      // Clamp: on the three-stage line tap_sel=3 reads stage 2
      do_flush();
      in_valid = 1'b1;
      w0       = 8'($urandom);
      in_data  = w0;
      step();
      for (int i = 0; i < 2; i++) begin
         in_data = 8'($urandom);
         step();
      end
      tap = 2'd3;
      #1;
      check("clamp.data", 32'(bus3.out_data), 32'(w0));
      check("clamp.valid", 32'(bus3.out_valid), 32'h1);
      check_model("clamp");

      // Random traffic, including same-cycle tap changes
      for (int i = 0; i < 300; i++) begin
         en       = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 19) == 0);
         in_valid = 1'($urandom);
         in_data  = 8'($urandom);
         tap      = 2'($urandom);
         step();
         check_model("rand");
         tap = 2'($urandom);
         #1;
         check_model("rand.tap");
      end
      flush = 1'b0;

      // Reset mid-stream clears everything without waiting for an edge
      en = 1'b1;
      do_flush();
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h11 * i);
         step();
      end
      in_valid = 1'b0;
      check("midrst.before.count", 32'(bus4.stage_count), 32'd4);
      #2;
      rst_n = 1'b0;
      hist4.delete();
      hist3.delete();
      for (int t = 0; t < 4; t++) begin
         tap = 2'(t);
         #1;
         check($sformatf("midrst.valid.t%0d", t), 32'(bus4.out_valid), 32'h0);
         check($sformatf("midrst.data.t%0d", t), 32'(bus4.out_data), 32'h00);
      end
      check("midrst.count", 32'(bus4.stage_count), 32'd0);
      check("midrst.full", 32'(bus4.full), 32'h0);
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      step();
      check_model("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
